// File: rtl/pwm_ramp_sequencer.sv
// Walks the PWM duty toward a commanded target in bounded steps, only at PWM period boundaries.
// Latency: duty_load/duty_out one cycle after the stepping period_end; done one cycle after a no-op accept.
// Backpressure: cmd_ready is low while ramping or disabled; the requester holds cmd_valid until accepted.
module pwm_ramp_sequencer #(
    parameter int WIDTH  = 8,
    parameter int RATE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_target,
    input  logic [WIDTH-1:0]  cmd_step,
    input  logic [RATE_W-1:0] cmd_rate,
    input  logic              abort,
    input  logic              period_end,
    output logic [WIDTH-1:0]  duty_out,
    output logic              duty_load,
    output logic              busy,
    output logic              done
);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t              state, state_nxt;
    logic [RATE_W-1:0]   cnt, cnt_nxt;
    logic [RATE_W-1:0]   rate_q, rate_nxt;
    logic [WIDTH-1:0]    target_q, target_nxt;
    logic [WIDTH-1:0]    step_q, step_nxt;
    logic [WIDTH-1:0]    duty_nxt;
    logic                load_nxt, busy_nxt, done_nxt, ready_nxt;
    logic                accept;
    logic                going_up;
    logic [WIDTH-1:0]    diff, stepped;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rate_nxt   = rate_q;
        target_nxt = target_q;
        step_nxt   = step_q;
        duty_nxt   = duty_out;
        load_nxt   = 1'b0;
        done_nxt   = 1'b0;
        busy_nxt   = busy;
        ready_nxt  = 1'b0;

        accept   = ena & cmd_valid & cmd_ready & (state == IDLE);
        // Distance is taken on the difference so saturation never wraps.
        going_up = (target_q >= duty_out);
        diff     = going_up ? (target_q - duty_out) : (duty_out - target_q);
        stepped  = going_up ? (duty_out + step_q) : (duty_out - step_q);

        if (ena) begin
            ready_nxt = (state == IDLE) & ~accept;
            case (state)
                IDLE: begin
                    if (accept) begin
                        target_nxt = cmd_target;
                        step_nxt   = (cmd_step == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : cmd_step;
                        rate_nxt   = cmd_rate;
                        cnt_nxt    = '0;
                        if (cmd_target == duty_out) begin
                            done_nxt = 1'b1;
                        end else begin
                            state_nxt = RAMP;
                            busy_nxt  = 1'b1;
                        end
                    end
                end
                RAMP: begin
                    if (abort) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end else if (period_end) begin
                        if (cnt != rate_q) begin
                            cnt_nxt = cnt + RATE_W'(1);
                        end else begin
                            cnt_nxt  = '0;
                            load_nxt = 1'b1;
                            if (diff <= step_q) begin
                                duty_nxt  = target_q;
                                done_nxt  = 1'b1;
                                busy_nxt  = 1'b0;
                                state_nxt = IDLE;
                            end else begin
                                duty_nxt = stepped;
                            end
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rate_q    <= '0;
            target_q  <= '0;
            step_q    <= '0;
            duty_out  <= '0;
            duty_load <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rate_q    <= rate_nxt;
            target_q  <= target_nxt;
            step_q    <= step_nxt;
            duty_out  <= duty_nxt;
            duty_load <= load_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            cmd_ready <= ready_nxt;
        end
    end

endmodule

// File: doc/pwm_ramp_sequencer.md
Name: pwm_ramp_sequencer

Overview:
Duty-cycle sequencer for the PWM generator core. It accepts a target duty, step size and step rate through a valid/ready command port. It then walks the PWM duty register toward the target in bounded increments, and updates only at PWM period boundaries so the output never glitches mid-period. Sits between the top-level pin decode (ui_in/uio_in) and the PWM counter/comparator; it provides soft-start and fade without host involvement.

Parameters:
WIDTH, 8, duty/target/step width in bits
RATE_W, 8, width of the periods-per-step field and its internal counter

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  design enable; low = freeze
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_target  input  WIDTH  target duty
cmd_step  input  WIDTH  max duty change per step; 0 treated as 1
cmd_rate  input  RATE_W  PWM periods between steps minus 1 (0 = step every period)
abort  input  1  stop ramp, hold current duty
period_end  input  1  one-cycle pulse from PWM core at counter wrap
duty_out  output  WIDTH  duty value driven to PWM comparator
duty_load  output  1  one-cycle strobe; PWM core latches duty_out
busy  output  1  ramp in progress
done  output  1  one-cycle pulse; target reached

Behaviour:
- One clock domain. Reset is asynchronous and active-low. While reset is low, and immediately on its assertion: duty_out=0, duty_load=0, busy=0, done=0, cmd_ready=0. The FSM goes to IDLE, the rate counter to 0, and the latched target/step/rate to 0. cmd_ready goes high on the first edge after reset release if ena=1.
- All outputs are registered. cmd_ready = (state==IDLE) & ena, registered.
- FSM states: IDLE, RAMP.
- IDLE: accept when cmd_valid & cmd_ready. Latch target, step (0 becomes 1) and rate; clear rate counter; cmd_ready=0 from the next cycle.
  - target == duty_out: stay IDLE; done=1 on the next cycle; no duty_load.
  - Otherwise: go to RAMP with busy=1 on the next cycle.
- RAMP: on each cycle with period_end=1 and ena=1:
  - If cnt != rate: cnt++.
  - If cnt == rate: cnt<=0 and perform a step.
- Step arithmetic, unsigned, computed on differences so there is no overflow or wrap:
  - d = |target - duty_out|.
  - If d <= step: duty_out <= target.
  - Else: duty_out <= duty_out ± step, toward target.
  - Examples: 200 → 255 with step 100 gives 255 in one step; 10 → 0 with step 16 gives 0.
- Each step: duty_load=1 for one cycle, coincident with the new duty_out value, i.e. the cycle after the period_end pulse.
- When the step lands on target: done=1 in the same cycle as that final duty_load. busy=0 and state IDLE from that cycle. cmd_ready rises the cycle after.
- period_end outside RAMP is ignored.
- abort (RAMP only): next cycle state=IDLE, busy=0, duty_out held, no duty_load, no done.
  - abort wins over a simultaneous step; that step is discarded.
  - abort in IDLE has no effect.
- ena=0: FSM, counter and duty_out frozen; period_end ignored; cmd_ready=0; duty_load/done forced 0. The ramp resumes from the frozen state when ena returns.
- cmd_valid during RAMP is not accepted. The requester holds the command until cmd_ready.
- Reset mid-ramp: duty_out goes to 0 asynchronously. The PWM core takes its own reset and therefore also returns to 0.
- Latency:
  - Command accept to first possible step: first period_end after (rate+1) periods.
  - Period_end to duty_load: 1 cycle.

Test Plan:
- Reset: hold rst_n=0, drive random inputs -> duty_out=0, duty_load=0, busy=0, done=0, cmd_ready=0. Release with ena=1 -> cmd_ready=1 after one edge. Assert rst_n low mid-ramp -> duty_out=0 without a clock edge.
- Ramp up: from 0, target=40, step=16, rate=0, three period_end pulses -> duty_load with duty_out=16, then 32, then 40. done coincides with the 40 load; busy falls the same cycle; cmd_ready rises next cycle.
- Ramp down with rate: duty 40, target=0, step=16, rate=2, nine period_end pulses -> loads on the 3rd, 6th and 9th pulses with values 24, 8, 0. No load on any other pulse.
- Saturation and zero step:
  - duty 200, target=255, step=100 -> single load to 255 plus done.
  - step=0, duty 5, target=7 -> loads of 6 then 7.
- No-op and abort:
  - target equal to current duty -> done one cycle after accept; no duty_load.
  - Abort asserted on the same cycle as a stepping period_end -> no load; duty held; busy=0; no done.
- Enable freeze: ena=0 for several period_end pulses mid-ramp -> no loads; cmd_ready=0. Restore ena=1 -> the ramp continues with the counter value it held when frozen.
